// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_ctrl_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        ACK       = 2'd3
    } state_e;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bundle of requester-side and transmitter-side signals around the scheduler.
// master: the environment (requesters plus uart_trans); slave: the scheduler.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    import uart_ctrl_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req;
    logic [UART_DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]             ack;
    logic [UART_DATA_W-1:0]         tx_data;
    logic                           tx_enable;
    logic                           tx_done;
    logic                           busy;
    logic [ID_W-1:0]                grant_id;
    logic                           timeout_err;

    modport master (
        output req, req_data, tx_done,
        input  ack, tx_data, tx_enable, busy, grant_id, timeout_err
    );

    modport slave (
        input  req, req_data, tx_done,
        output ack, tx_data, tx_enable, busy, grant_id, timeout_err
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search starts just after last_grant and wraps.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic               valid,
    output logic [ID_W-1:0]    winner
);

    // cand_idx[k] is the requester examined at priority rank k (0 = highest)
    logic [ID_W-1:0]    cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand_idx[gi] = ID_W'((32'(last_grant) + 32'(gi) + 32'd1) % 32'(NUM_REQ));
        assign cand_hit[gi] = req[cand_idx[gi]];
    end

    assign valid = |cand_hit;

    // Walk ranks from lowest to highest priority so the highest-priority hit wins
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                winner = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ requesters, round-robin.
// Optional WAIT_DONE watchdog enabled by defining UART_TX_TIMEOUT_EN.
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic clk,
    input  logic reset,
    uart_tx_scheduler_if.slave bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("uart_tx_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        last_grant_q, last_grant_d;
    logic [ID_W-1:0]        grant_id_q, grant_id_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                   tx_enable_q, tx_enable_d;
    logic                   busy_q, busy_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;

    logic                   arb_valid;
    logic [ID_W-1:0]        arb_winner;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (bus.req),
        .last_grant (last_grant_q),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

`ifdef UART_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_hit;
    logic             timeout_err_q, timeout_err_d;

    // Fires on the last permitted WAIT_DONE cycle
    assign timeout_hit = (state_q == WAIT_DONE) &&
                         (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive WAIT_DONE cycles; leaving the state clears the count
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == WAIT_DONE && state_d == WAIT_DONE) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Watchdog counter and sticky error register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // Next-state logic; every output is computed from the next state and registered
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        tx_data_d    = tx_data_q;
`ifdef UART_TX_TIMEOUT_EN
        timeout_err_d = timeout_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d    = LAUNCH;
                    grant_id_d = arb_winner;
                    tx_data_d  = bus.req_data[int'(arb_winner) * UART_DATA_W +: UART_DATA_W];
                end
            end
            LAUNCH: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // tx_done takes precedence over a simultaneous timeout
                if (bus.tx_done) begin
                    state_d = ACK;
                end
`ifdef UART_TX_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d       = ACK;
                    timeout_err_d = 1'b1;
                end
`endif
            end
            ACK: begin
                state_d      = IDLE;
                last_grant_d = grant_id_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_enable_d = (state_d == LAUNCH);
        busy_d      = (state_d != IDLE);
        ack_d       = '0;
        if (state_d == ACK) begin
            ack_d[grant_id_d] = 1'b1;
        end
    end

    // State and output registers; reset gives requester 0 first priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            tx_data_q    <= '0;
            tx_enable_q  <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tx_data_q    <= tx_data_d;
            tx_enable_q  <= tx_enable_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_enable = tx_enable_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_id_q;

endmodule
